// File: rtl/sc_gen_pkg.sv
// Shared constants, state encoding and LFSR helper for the 15-lane
// stochastic stream generator.
package sc_gen_pkg;

    // Number of parallel stochastic lanes and the threshold spacing between them.
    localparam int LANES     = 15;
    localparam int LANE_STEP = 16;

    // LFSR value after reset. Any nonzero value works; 8'h01 keeps traces readable.
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

    // Feedback taps r[7], r[5], r[4], r[3] (maximal-length, period 255).
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

    // Generator states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } gen_state_e;

    // Plain-vector views of the states for the legacy-style state register.
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_GEN  = GEN;

    // One Fibonacci step: shift left, feedback enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], ^(r & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous reset, parallel load and step enable.
// Load has priority over stepping so a new seed always wins.
module sc_lfsr8
    import sc_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] state
);

    // State register: reset to the default seed, load a seed, or advance one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sc_stream_gen_15.sv
// Stochastic bit-stream generator feeding a 15-lane parallel counter.
// One request (probability numerator, length, optional seed) produces
// a burst of beats; each beat carries 15 bits, lane i being
// value > ((lfsr + 16*i) mod 256).
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may change freely.
//   in  side: in_ready is high only in IDLE, so requests arriving during
//             a burst are ignored and never queued.
//   out side: out_valid is high for the whole of GEN; out_stream/out_last
//             are pure functions of registered state, so they cannot move
//             while the consumer stalls.
// Only INPUT_WIDTH = 8 is supported, since the lane thresholds are 8-bit.
module sc_stream_gen_15
    import sc_gen_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_value,
    input  logic [LEN_WIDTH-1:0]   in_len,
    input  logic [7:0]             in_seed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_stream,
    output logic                   out_last,
    output logic [0:0]             dbg_state,
    output logic [7:0]             dbg_lfsr
);

    logic [0:0]             state_q;
    logic [INPUT_WIDTH-1:0] value_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [7:0]             lfsr_q;

    logic in_gen;
    logic req_accept;
    logic beat_fire;
    logic last_beat;
    logic lfsr_load;

    // Handshake and control decode from the registered state.
    always_comb begin
        in_gen     = (state_q == ST_GEN);
        req_accept = (state_q == ST_IDLE) && in_valid;
        beat_fire  = in_gen && out_ready;
        last_beat  = (cnt_q == LEN_WIDTH'(1));
        lfsr_load  = req_accept && (in_seed != 8'h00);
    end

    // FSM, latched probability and remaining-beat counter.
    // A length of 0 wraps through all 2^LEN_WIDTH counts before reaching 1,
    // which is what gives it the full-range meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        value_q <= in_value;
                        cnt_q   <= in_len;
                        state_q <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Random source: reseeded on acceptance when a seed is given, stepped
    // once per transferred beat so a stalled beat keeps its random value.
    sc_lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (in_seed),
        .en    (beat_fire),
        .state (lfsr_q)
    );

    // Lane comparators: each lane sees the LFSR value rotated by its own
    // offset, so lanes are decorrelated within a beat at no extra LFSR cost.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic [7:0] LANE_OFFS = 8'((LANE_STEP * g) % 256);
        logic [7:0] thresh;
        assign thresh        = lfsr_q + LANE_OFFS;
        assign out_stream[g] = in_gen && (value_q > thresh);
    end

    // Port outputs: all derived from registers, no input-to-output path.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = in_gen;
        out_last  = in_gen && last_beat;
        dbg_state = state_q;
        dbg_lfsr  = lfsr_q;
    end

endmodule
